qspinor_rd_seq: RTL and testbench
=================================

Name: qspinor_rd_seq

Overview:
- Read-transaction sequencer for the QSPI NOR PHY (`qspinor_io`).
- Takes a byte-read request (address, length) from the bus side and drives qspi_csb.
- Issues ordered tx/dmy/rx unit requests to `qspinor_io`: opcode, 24-bit address, dummy cycles, data.
- Streams received bytes back. Sits between the flash bus slave and `qspinor_io`.

Parameters:
- LEN_W, 8, width of req_len (burst = req_len+1 bytes, max 2^LEN_W).
- DUMMY_CYCLES, 8, sclk dummy cycles in quad mode (≥ MODE_CYCLES).
- MODE_CYCLES, 2, leading dummy cycles driven with pattern 4'hF (dir=1); remainder released (dir=0).
- CS_HIGH_MIN, 2, minimum clk cycles csb stays high between transactions.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cfg_quad  in  1  0: 1-1-1 read (opcode 8'h03, no dummy); 1: 4-4-4 read (opcode 8'hEB, DUMMY_CYCLES); sampled at request accept
- req_valid  in  1  read request
- req_ready  out  1  request accepted when valid&ready
- req_addr  in  24  start byte address
- req_len  in  LEN_W  byte count minus 1
- rd_valid  out  1  one-cycle pulse, rd_data valid
- rd_data  out  8  read byte
- rd_last  out  1  with rd_valid on final byte
- busy  out  1  high from accept until CS_HIGH done
- io_width  out  2  0=x1, 1=x2, 2=x4; held stable from req to resp
- io_tx_req  out  1  one-cycle pulse: transmit io_txq_d
- io_txq_rdy  out  1  tx data valid (high while tx unit outstanding)
- io_txq_d  out  8  tx byte
- io_tx_resp  in  1  one-cycle pulse: tx byte done
- io_rx_req  out  1  one-cycle pulse: receive one byte
- io_rxq_rdy  out  1  high (sink always ready)
- io_rxq_d  in  8  rx byte, valid in io_rx_resp cycle
- io_rx_resp  in  1  one-cycle pulse: rx byte done
- io_dmy_req  out  1  one-cycle pulse: one dummy sclk cycle
- io_dmy_dir  out  1  1=drive io_dmy_pattern_out, 0=release
- io_dmy_pattern_out  out  4  dummy drive pattern
- io_dmy_resp  in  1  one-cycle pulse: dummy cycle done
- qspi_csb  out  1  flash chip select, active low

Behaviour:
- Reset values: qspi_csb=1; req_ready=1; busy, rd_valid, rd_last, all io_*_req, io_txq_rdy, io_dmy_dir = 0; io_width=0; io_txq_d=0; io_dmy_pattern_out=0; rd_data=0; io_rxq_rdy=1. State IDLE.
- Sync rst mid-transaction: next edge forces all reset values; no CS_HIGH wait, no rd_valid.
- Unit protocol: at most one unit outstanding; req pulsed 1 cycle; next req earliest the cycle after resp. Resp with no outstanding unit is ignored.
- States:
  - IDLE: req_ready=1. On valid&ready latch addr, len, cfg_quad; set busy; csb<=0 -> CS_SETUP.
  - CS_SETUP: 1 cycle -> CMD.
  - CMD: tx opcode (03 or EB); width 0 (spi) or 2 (quad) -> ADDR.
  - ADDR: tx addr[23:16], [15:8], [7:0] in order, same width. Then -> DUMMY if quad, else DATA.
  - DUMMY: DUMMY_CYCLES dmy units, counter down. First MODE_CYCLES use dir=1, pattern 4'hF; rest dir=0, pattern 0 -> DATA.
  - DATA: rx units, same width. Each rx_resp: rd_valid=1, rd_data=io_rxq_d (registered, 1-cycle latency). Count decrements; rd_last on the byte with count==0 -> CS_HIGH.
  - CS_HIGH: csb<=1; hold CS_HIGH_MIN cycles -> IDLE (busy clears same edge).
- req_len=0: exactly one byte. req_len=max: 2^LEN_W bytes; counter must not wrap early.
- Internal address wraps 24'hFFFFFF->0; the flash continues, controller does not re-address.
- req_valid while not ready: held, no effect.

Optional Feature:
- Macro QSPINOR_RD_SEQ_CONT_EN.
- Without it: behaviour as above.
- With it, after rd_last:
  - csb stays low; enter IDLE_CONT with req_ready=1 and next_addr = last addr+1.
  - Request with req_addr==next_addr and same cfg_quad: go straight to DATA (no CMD/ADDR/DUMMY).
  - Any other request: csb high for CS_HIGH_MIN, then normal CS_SETUP path with the latched request.
  - In IDLE_CONT, busy=0 and csb=0.

Test Plan:
- cfg_quad=0, addr 24'h000100, len 0: tx 03,00,01,00 at width 0; 0 dmy; 1 rx; one rd_valid with rd_last; csb high ≥2 cycles.
- cfg_quad=1, addr 24'h00ABCD, len 3: tx EB,00,AB,CD at width 2; 8 dmy (first 2 dir=1/4'hF); 4 rd_valid bytes, rd_last on 4th.
- rst asserted during DUMMY: next edge csb=1, no further io reqs, req_ready=1.
- Back-to-back requests: second accept no earlier than CS_HIGH_MIN cycles after csb rise; req_ready low meanwhile.
- len=8'hFF with io model: exactly 256 rd_valid, rd_last only on 256th.
- CONT_EN: read 0x10 len 3, then 0x14: no tx/dmy, csb never rises, 4+ bytes. Then request 0x40: csb high 2 cycles, full CMD sequence.

Source files
------------

// File: rtl/qspinor_rd_seq.sv
// Read-transaction sequencer for the qspinor_io PHY: opcode, 24-bit address, dummy cycles, data.
// Optional macro QSPINOR_RD_SEQ_CONT_EN keeps csb low after a burst so a sequential follow-up read skips straight to data.
module qspinor_rd_seq #(
    parameter int LEN_W        = 8,
    parameter int DUMMY_CYCLES = 8,
    parameter int MODE_CYCLES  = 2,
    parameter int CS_HIGH_MIN  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_quad,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [23:0]      req_addr,
    input  logic [LEN_W-1:0] req_len,
    output logic             rd_valid,
    output logic [7:0]       rd_data,
    output logic             rd_last,
    output logic             busy,
    output logic [1:0]       io_width,
    output logic             io_tx_req,
    output logic             io_txq_rdy,
    output logic [7:0]       io_txq_d,
    input  logic             io_tx_resp,
    output logic             io_rx_req,
    output logic             io_rxq_rdy,
    input  logic [7:0]       io_rxq_d,
    input  logic             io_rx_resp,
    output logic             io_dmy_req,
    output logic             io_dmy_dir,
    output logic [3:0]       io_dmy_pattern_out,
    input  logic             io_dmy_resp,
    output logic             qspi_csb
);

    localparam int DMY_W = (DUMMY_CYCLES > 1) ? $clog2(DUMMY_CYCLES) : 1;
    localparam int CS_W  = (CS_HIGH_MIN > 1) ? $clog2(CS_HIGH_MIN) : 1;
    localparam logic [DMY_W-1:0] DMY_LOAD = DMY_W'(DUMMY_CYCLES - 1);
    localparam logic [CS_W-1:0]  CS_LOAD  = CS_W'(CS_HIGH_MIN - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CS_SETUP, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_CS_HIGH, S_IDLE_CONT
    } state_t;

    state_t             state, state_nxt;
    logic               pend;
    logic [23:0]        addr_q;
    logic [LEN_W-1:0]   len_cnt;
    logic               quad_q;
    logic [1:0]         addr_idx;
    logic [DMY_W-1:0]   dmy_cnt;
    logic [CS_W-1:0]    cs_cnt;
    logic               vld_p1;
    logic               last_p1;
    logic [7:0]         data_p1;

    logic accept, tx_st, unit_st, issue, unit_done;

`ifdef QSPINOR_RD_SEQ_CONT_EN
    logic restart;
    logic cont_hit;
    assign cont_hit = (req_addr == addr_q) && (cfg_quad == quad_q);
`endif

    assign accept    = req_valid && req_ready;
    assign tx_st     = (state == S_CMD) || (state == S_ADDR);
    assign unit_st   = tx_st || (state == S_DUMMY) || (state == S_DATA);
    // A unit is requested whenever the state needs one and none is in flight; pend blocks re-issue until resp.
    assign issue     = unit_st && !pend;
    assign unit_done = pend && ((tx_st && io_tx_resp) ||
                                ((state == S_DUMMY) && io_dmy_resp) ||
                                ((state == S_DATA) && io_rx_resp));

    assign rd_valid   = vld_p1;
    assign rd_last    = last_p1;
    assign rd_data    = data_p1;
    assign io_rxq_rdy = 1'b1;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (accept) state_nxt = S_CS_SETUP;
            S_CS_SETUP: state_nxt = S_CMD;
            S_CMD:      if (unit_done) state_nxt = S_ADDR;
            S_ADDR:     if (unit_done && addr_idx == 2'd2) state_nxt = quad_q ? S_DUMMY : S_DATA;
            S_DUMMY:    if (unit_done && dmy_cnt == '0) state_nxt = S_DATA;
            S_DATA: begin
                if (unit_done && len_cnt == '0) begin
`ifdef QSPINOR_RD_SEQ_CONT_EN
                    state_nxt = S_IDLE_CONT;
`else
                    state_nxt = S_CS_HIGH;
`endif
                end
            end
            S_CS_HIGH: begin
                if (cs_cnt == '0) begin
`ifdef QSPINOR_RD_SEQ_CONT_EN
                    state_nxt = restart ? S_CS_SETUP : S_IDLE;
`else
                    state_nxt = S_IDLE;
`endif
                end
            end
            S_IDLE_CONT: begin
`ifdef QSPINOR_RD_SEQ_CONT_EN
                if (accept) state_nxt = cont_hit ? S_DATA : S_CS_HIGH;
`else
                state_nxt = S_IDLE;
`endif
            end
            default:    state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend     <= 1'b0;
            addr_q   <= '0;
            len_cnt  <= '0;
            quad_q   <= 1'b0;
            addr_idx <= '0;
            dmy_cnt  <= DMY_LOAD;
            cs_cnt   <= CS_LOAD;
            vld_p1   <= 1'b0;
            last_p1  <= 1'b0;
            data_p1  <= '0;
`ifdef QSPINOR_RD_SEQ_CONT_EN
            restart  <= 1'b0;
`endif
        end else begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
            if (issue)          pend <= 1'b1;
            else if (unit_done) pend <= 1'b0;
            if (accept) begin
                addr_q   <= req_addr;
                len_cnt  <= req_len;
                quad_q   <= cfg_quad;
                addr_idx <= '0;
                dmy_cnt  <= DMY_LOAD;
            end
            if (state == S_ADDR && unit_done)  addr_idx <= addr_idx + 2'd1;
            if (state == S_DUMMY && unit_done) dmy_cnt  <= dmy_cnt - 1'b1;
            // Data stage: response byte registered for one cycle; addr_q tracks the next sequential address.
            if (state == S_DATA && unit_done) begin
                vld_p1  <= 1'b1;
                data_p1 <= io_rxq_d;
                last_p1 <= (len_cnt == '0);
                len_cnt <= len_cnt - 1'b1;
                addr_q  <= addr_q + 24'd1;
            end
            if (state_nxt == S_CS_HIGH && state != S_CS_HIGH) cs_cnt <= CS_LOAD;
            else if (state == S_CS_HIGH && cs_cnt != '0)      cs_cnt <= cs_cnt - 1'b1;
`ifdef QSPINOR_RD_SEQ_CONT_EN
            if (state == S_IDLE_CONT && accept)       restart <= !cont_hit;
            else if (state == S_CS_HIGH && cs_cnt == '0) restart <= 1'b0;
`endif
        end
    end

    always_comb begin
        req_ready          = (state == S_IDLE) || (state == S_IDLE_CONT);
        busy               = !((state == S_IDLE) || (state == S_IDLE_CONT));
        qspi_csb           = (state == S_IDLE) || (state == S_CS_HIGH);
        io_width           = (state != S_IDLE && quad_q) ? 2'd2 : 2'd0;
        io_tx_req          = issue && tx_st;
        io_txq_rdy         = tx_st;
        io_txq_d           = 8'h00;
        io_rx_req          = issue && (state == S_DATA);
        io_dmy_req         = issue && (state == S_DUMMY);
        io_dmy_dir         = 1'b0;
        io_dmy_pattern_out = 4'h0;
        case (state)
            S_CMD:  io_txq_d = quad_q ? 8'hEB : 8'h03;
            S_ADDR: begin
                case (addr_idx)
                    2'd0:    io_txq_d = addr_q[23:16];
                    2'd1:    io_txq_d = addr_q[15:8];
                    default: io_txq_d = addr_q[7:0];
                endcase
            end
            S_DUMMY: begin
                // Mode cycles come first while the counter is still high.
                if (int'(dmy_cnt) >= DUMMY_CYCLES - MODE_CYCLES) begin
                    io_dmy_dir         = 1'b1;
                    io_dmy_pattern_out = 4'hF;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_qspinor_rd_seq.sv
// Scoreboard bench for qspinor_rd_seq: an io/flash responder and a read-data monitor pop expectations
// queued by the request driver, which derives them from the read-protocol rules and a memory function.
module tb_qspinor_rd_seq;
    localparam int LEN_W        = 8;
    localparam int DUMMY_CYCLES = 8;
    localparam int MODE_CYCLES  = 2;
    localparam int CS_HIGH_MIN  = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_quad;
    logic             req_valid;
    logic             req_ready;
    logic [23:0]      req_addr;
    logic [LEN_W-1:0] req_len;
    logic             rd_valid;
    logic [7:0]       rd_data;
    logic             rd_last;
    logic             busy;
    logic [1:0]       io_width;
    logic             io_tx_req, io_txq_rdy, io_tx_resp;
    logic [7:0]       io_txq_d;
    logic             io_rx_req, io_rxq_rdy, io_rx_resp;
    logic [7:0]       io_rxq_d;
    logic             io_dmy_req, io_dmy_dir, io_dmy_resp;
    logic [3:0]       io_dmy_pattern_out;
    logic             qspi_csb;

    qspinor_rd_seq #(
        .LEN_W(LEN_W), .DUMMY_CYCLES(DUMMY_CYCLES), .MODE_CYCLES(MODE_CYCLES), .CS_HIGH_MIN(CS_HIGH_MIN)
    ) dut (
        .clk(clk), .rst(rst), .cfg_quad(cfg_quad), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_len(req_len), .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
        .busy(busy), .io_width(io_width), .io_tx_req(io_tx_req), .io_txq_rdy(io_txq_rdy),
        .io_txq_d(io_txq_d), .io_tx_resp(io_tx_resp), .io_rx_req(io_rx_req), .io_rxq_rdy(io_rxq_rdy),
        .io_rxq_d(io_rxq_d), .io_rx_resp(io_rx_resp), .io_dmy_req(io_dmy_req), .io_dmy_dir(io_dmy_dir),
        .io_dmy_pattern_out(io_dmy_pattern_out), .io_dmy_resp(io_dmy_resp), .qspi_csb(qspi_csb)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // io events are {kind, width, byte}: kind 0=tx, 1=dummy ({dir,pattern} in the byte), 2=rx
    logic [11:0] exp_io[$];
    logic [8:0]  exp_rd[$];

    bit          cont_ok = 0;
    logic [23:0] cont_addr = '0;
    bit          cont_quad = 0;
    bit          inj_stray = 0;
    int          csb_rises = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        return a[7:0] ^ (a[15:8] + 8'h3C) ^ a[23:16] ^ 8'h5A;
    endfunction

    // Reference model: what a read of (a, len, q) must look like on the io side and on rd_*.
    task automatic push_read(input logic [23:0] a, input int len, input bit q);
        bit          hit;
        logic [1:0]  w;
        logic [23:0] ai;
        hit = 0;
`ifdef QSPINOR_RD_SEQ_CONT_EN
        hit = cont_ok && (a == cont_addr) && (q == cont_quad);
`endif
        w = q ? 2'd2 : 2'd0;
        if (!hit) begin
            exp_io.push_back({2'd0, w, q ? 8'hEB : 8'h03});
            exp_io.push_back({2'd0, w, a[23:16]});
            exp_io.push_back({2'd0, w, a[15:8]});
            exp_io.push_back({2'd0, w, a[7:0]});
            if (q) for (int i = 0; i < DUMMY_CYCLES; i++)
                exp_io.push_back({2'd1, w, (i < MODE_CYCLES) ? 8'h1F : 8'h00});
        end
        for (int i = 0; i <= len; i++) begin
            ai = a + 24'(i);
            exp_io.push_back({2'd2, w, 8'h00});
            exp_rd.push_back({(i == len), mem_byte(ai)});
        end
`ifdef QSPINOR_RD_SEQ_CONT_EN
        cont_ok   = 1;
        cont_addr = a + 24'(len + 1);
        cont_quad = q;
`endif
    endtask

    task automatic do_read(input logic [23:0] a, input int len, input bit q);
        int k;
        push_read(a, len, q);
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = a;
        req_len   = LEN_W'(len);
        cfg_quad  = q;
        k = 0;
        while (!req_ready && k < 5000) begin
            chk("ready_vs_busy", busy, 1);
            @(negedge clk);
            k++;
        end
        chk("accept_wait", req_ready, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = 24'($urandom);
        req_len   = LEN_W'($urandom);
        cfg_quad  = 1'($urandom);
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (!(exp_rd.size() == 0 && exp_io.size() == 0 && !busy) && k < 5000) begin
            @(negedge clk);
            k++;
        end
        chk("done_in_budget", (k < 5000), 1);
    endtask

    // io responder + flash model: one unit at a time, random latency, decodes address from tx bytes.
    bit          outst = 0, resp_hi = 0;
    int          lat = 0, bidx = 0, kind = 0, nreq;
    logic [23:0] ptr = '0;
    logic [11:0] act, expv;
    initial begin
        io_tx_resp = 0; io_rx_resp = 0; io_dmy_resp = 0; io_rxq_d = 8'h00;
        forever begin
            @(negedge clk);
            if (resp_hi) begin
                io_tx_resp = 0; io_rx_resp = 0; io_dmy_resp = 0;
                io_rxq_d = 8'($urandom);
                resp_hi = 0;
                outst = 0;
            end
            if (qspi_csb === 1'b1) bidx = 0;
            nreq = int'(io_tx_req === 1'b1) + int'(io_rx_req === 1'b1) + int'(io_dmy_req === 1'b1);
            if (nreq != 0) begin
                chk("one_req", nreq, 1);
                chk("req_while_outstanding", outst, 0);
                chk("csb_low_on_req", qspi_csb, 0);
                if (io_tx_req)       begin act = {2'd0, io_width, io_txq_d}; kind = 0; end
                else if (io_dmy_req) begin act = {2'd1, io_width, 3'b000, io_dmy_dir, io_dmy_pattern_out}; kind = 1; end
                else                 begin act = {2'd2, io_width, 8'h00}; kind = 2; end
                if (exp_io.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL io_unexpected: got %0h, required no request", act);
                end else begin
                    expv = exp_io.pop_front();
                    chk("io_event", act, expv);
                end
                if (io_tx_req) begin
                    chk("txq_rdy", io_txq_rdy, 1);
                    if (bidx >= 1 && bidx <= 3) ptr = {ptr[15:0], io_txq_d};
                    bidx++;
                end
                outst = 1;
                lat = $urandom_range(0, 3);
            end else if (outst && !resp_hi) begin
                if (lat == 0) begin
                    if (kind == 0) io_tx_resp = 1;
                    else if (kind == 1) io_dmy_resp = 1;
                    else begin
                        io_rx_resp = 1;
                        io_rxq_d = mem_byte(ptr);
                        ptr = ptr + 24'd1;
                    end
                    resp_hi = 1;
                end else lat--;
            end else if (inj_stray && !outst && !resp_hi) begin
                io_tx_resp = 1; io_rx_resp = 1; io_dmy_resp = 1;
                resp_hi = 1;
            end
        end
    end

    logic [8:0] rd_exp;
    initial begin
        forever begin
            @(negedge clk);
            if (rd_valid === 1'b1) begin
                if (exp_rd.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rd_unexpected: got %0h, required no byte", {rd_last, rd_data});
                end else begin
                    rd_exp = exp_rd.pop_front();
                    chk("rd_byte", {rd_last, rd_data}, rd_exp);
                end
            end
        end
    end

    int  hi_cnt = 0;
    bit  csb_prev = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (qspi_csb === 1'b1) begin
                if (!csb_prev) csb_rises++;
                hi_cnt++;
                csb_prev = 1;
            end else begin
                if (hi_cnt > 0 && rst === 1'b0) chk("csb_high_min", (hi_cnt >= CS_HIGH_MIN), 1);
                hi_cnt = 0;
                csb_prev = 0;
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          rises0, len;
        bit          q;
        logic [23:0] a;
        rst = 1; req_valid = 0; req_addr = '0; req_len = '0; cfg_quad = 0;
        repeat (3) @(negedge clk);
        chk("rst_csb", qspi_csb, 1);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_last", rd_last, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_io_width", io_width, 0);
        chk("rst_tx_req", io_tx_req, 0);
        chk("rst_rx_req", io_rx_req, 0);
        chk("rst_dmy_req", io_dmy_req, 0);
        chk("rst_txq_rdy", io_txq_rdy, 0);
        chk("rst_txq_d", io_txq_d, 0);
        chk("rst_dmy_dir", io_dmy_dir, 0);
        chk("rst_dmy_pat", io_dmy_pattern_out, 0);
        chk("rst_rxq_rdy", io_rxq_rdy, 1);
        rst = 0;

        // stray responses while idle must be ignored
        @(posedge clk); #1 inj_stray = 1;
        @(posedge clk); #1 inj_stray = 0;
        repeat (4) @(negedge clk);
        chk("stray_busy", busy, 0);
        chk("stray_csb", qspi_csb, 1);

        do_read(24'h000100, 0, 0);
        wait_done();
`ifndef QSPINOR_RD_SEQ_CONT_EN
        chk("csb_idle_high", qspi_csb, 1);
`endif
        do_read(24'h00ABCD, 3, 1);
        wait_done();

        // back-to-back: second request held while the first runs
        do_read(24'h2468A0, 5, 0);
        do_read(24'h13579B, 2, 1);
        wait_done();

        // reset during the dummy phase
        do_read(24'h123456, 7, 1);
        begin
            int k;
            k = 0;
            while (io_dmy_req !== 1'b1 && k < 300) begin
                @(negedge clk);
                k++;
            end
            chk("dummy_seen", io_dmy_req, 1);
        end
        rst = 1;
        @(posedge clk);
        #1;
        exp_io.delete();
        exp_rd.delete();
        cont_ok = 0;
        chk("midrst_csb", qspi_csb, 1);
        chk("midrst_req_ready", req_ready, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_rd_valid", rd_valid, 0);
        @(negedge clk);
        rst = 0;
        repeat (8) @(negedge clk);

        // full-length burst that also crosses the 24-bit address wrap
        do_read(24'hFFFF80, 255, 1);
        wait_done();

        for (int it = 0; it < 14; it++) begin
            q   = 1'($urandom_range(0, 1));
            len = $urandom_range(0, 12);
            a   = ($urandom_range(0, 3) == 0) ? 24'hFFFFFE : 24'($urandom);
            if (cont_ok && $urandom_range(0, 1) == 1) begin
                a = cont_addr;
                q = cont_quad;
            end
            do_read(a, len, q);
            if ($urandom_range(0, 2) != 0) wait_done();
        end
        wait_done();

`ifdef QSPINOR_RD_SEQ_CONT_EN
        do_read(24'h000010, 3, 0);
        wait_done();
        chk("cont_csb_low", qspi_csb, 0);
        chk("cont_busy", busy, 0);
        rises0 = csb_rises;
        do_read(24'h000014, 3, 0);
        wait_done();
        chk("cont_csb_rises", csb_rises, rises0);
        do_read(24'h000040, 1, 0);
        wait_done();
        chk("cont_restart_rises", csb_rises, rises0 + 1);
`else
        rises0 = csb_rises;
        do_read(24'h000010, 3, 0);
        wait_done();
        chk("csb_rise_per_read", csb_rises, rises0 + 1);
`endif

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
